// File: rtl/branch_stack.sv
// Branch checkpoint stack: snapshots the dispatch free list per branch, keeps each
// snapshot current with retiring T_old registers, and restores it on a mispredict.
module branch_stack #(
  parameter int NUM_BRANCHES     = 8,
  parameter int N                = 2,
  parameter int PHYS_REG_SZ_R10K = 64,
  parameter int NUM_SCALAR_BITS  = $clog2(N + 1),
  parameter int PHYS_REG_IDX_W   = $clog2(PHYS_REG_SZ_R10K)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 dispatch_branch_valid,
  input  logic [PHYS_REG_SZ_R10K-1:0]          dispatch_free_list,
  output logic [NUM_BRANCHES-1:0]              branch_tag_alloc,
  output logic                                 stack_full,
  output logic [NUM_BRANCHES-1:0]              branch_mask,
  input  logic                                 resolve_valid,
  input  logic [NUM_BRANCHES-1:0]              resolve_tag,
  input  logic                                 resolve_mispredict,
  input  logic [N-1:0][PHYS_REG_IDX_W-1:0]     phys_reg_retiring,
  input  logic [NUM_SCALAR_BITS-1:0]           num_retiring_valid,
  output logic [PHYS_REG_SZ_R10K-1:0]          free_list_restore,
  output logic                                 restore_flag,
  output logic [NUM_BRANCHES-1:0]              squash_mask
);

  localparam int NB = NUM_BRANCHES;
  localparam int PR = PHYS_REG_SZ_R10K;

  logic [NB-1:0]          valid_q, valid_d;
  logic [NB-1:0][PR-1:0]  snap_q, snap_d;
  logic [NB-1:0][NB-1:0]  dep_q, dep_d;

  logic [PR-1:0] retire_vec, snap_sel;
  logic [NB-1:0] gnt, alloc, squash, clr_mask;
  logic          res_ok, mispred, correct, full, found;

  always_comb begin
    retire_vec = '0;
    for (int i = 0; i < N; i++)
      if (i < int'(num_retiring_valid)) retire_vec[phys_reg_retiring[i]] = 1'b1;
  end

  // Tags that are not one-hot or name a dead entry are ignored entirely.
  assign res_ok  = resolve_valid && $onehot(resolve_tag) && |(resolve_tag & valid_q);
  assign mispred = res_ok && resolve_mispredict;
  assign correct = res_ok && !resolve_mispredict;
  assign full    = &valid_q;

  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    squash   = resolve_tag;
    snap_sel = '0;
    for (int e = 0; e < NB; e++) begin
      if (!valid_q[e] && !found) begin
        gnt[e] = 1'b1;
        found  = 1'b1;
      end
      if (valid_q[e] && |(dep_q[e] & resolve_tag)) squash[e] = 1'b1;
      if (resolve_tag[e]) snap_sel = snap_sel | snap_q[e];
    end
  end

  // A dispatching branch is younger than a mispredicting one, so it is dropped.
  assign alloc = (dispatch_branch_valid && !full && !mispred && !reset) ? gnt : '0;

  assign branch_tag_alloc  = alloc;
  assign stack_full        = reset ? 1'b0 : full;
  assign branch_mask       = reset ? '0 : valid_q;
  assign restore_flag      = mispred && !reset;
  assign squash_mask       = restore_flag ? squash : '0;
  assign free_list_restore = restore_flag ? (snap_sel | retire_vec) : '0;

  always_comb begin
    clr_mask = '0;
    if (correct) clr_mask = resolve_tag;
    if (mispred) clr_mask = squash;
    valid_d = (valid_q & ~clr_mask) | alloc;
    for (int e = 0; e < NB; e++) begin
      dep_d[e]  = dep_q[e] & ~clr_mask;
      snap_d[e] = valid_q[e] ? (snap_q[e] | retire_vec) : snap_q[e];
      if (alloc[e]) begin
        snap_d[e] = dispatch_free_list | retire_vec;
        dep_d[e]  = valid_q & ~clr_mask;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      snap_q  <= '0;
      dep_q   <= '0;
    end else begin
      valid_q <= valid_d;
      snap_q  <= snap_d;
      dep_q   <= dep_d;
    end
  end

endmodule
